// File: rtl/burst_ram_if.sv
// Request/response bus between the memory arbiter (master) and burst_ram (slave).
// Also supplies fallback MEM_READ/MEM_WRITE encodings when defines.v is not compiled first.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

interface burst_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_enable;
  logic                  mem_rw;
  logic                  mem_op_size;
  logic                  mem_finishes_op;
  logic [DATA_WIDTH-1:0] mem_write;
  logic                  mem_write_req;
  logic [DATA_WIDTH-1:0] mem_read;
  logic                  mem_read_valid;
  logic                  mem_last;

  modport master (
    output mem_addr, mem_enable, mem_rw, mem_op_size, mem_finishes_op, mem_write,
    input  mem_write_req, mem_read, mem_read_valid, mem_last
  );

  modport slave (
    input  mem_addr, mem_enable, mem_rw, mem_op_size, mem_finishes_op, mem_write,
    output mem_write_req, mem_read, mem_read_valid, mem_last
  );
endinterface

// File: rtl/burst_ram.sv
// Burst main-memory model behind the arbiter: critical-word-first wrapped read/write bursts.
// Array contents are undefined until written; INIT_FILE is accepted but has no effect.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module burst_ram #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    BURST_LEN    = 8,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = "ram_init.hex"
) (
  input  logic       clk,
  input  logic       rst,
  burst_ram_if.slave mem
);

  localparam int B  = $clog2(BURST_LEN);
  localparam int CW = B + 1;
  localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [WW-1:0] WAIT_INIT  = (READ_LATENCY > 0) ? WW'(READ_LATENCY - 1) : '0;
  localparam logic [CW-1:0] FULL_COUNT = CW'(BURST_LEN);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_READ_WAIT   = 3'd1;
  localparam logic [2:0] S_READ_BURST  = 3'd2;
  localparam logic [2:0] S_WRITE_BURST = 3'd3;
  localparam logic [2:0] S_DONE        = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CW-1:0]         count;
  logic [B-1:0]          idx;
  logic [WW-1:0]         wait_cnt;

  logic [DATA_WIDTH-1:0] mem_array [0:(2**ADDR_WIDTH)-1];

  logic                  final_word;
  logic                  rd_load;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // High address bits are fixed; the low B bits wrap within the aligned line.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] start,
                                                      input logic [B-1:0] k);
    word_addr = {start[ADDR_WIDTH-1:B], start[B-1:0] + k};
  endfunction

  always_comb begin
    final_word = ({1'b0, idx} == (count - CW'(1)));
    wr_en      = (state == S_WRITE_BURST) && mem.mem_enable && !rst;
    rd_load    = 1'b0;
    rd_addr    = word_addr(base_addr, idx + B'(1));
    case (state)
      S_IDLE: begin
        if (mem.mem_enable && (mem.mem_rw == `MEM_READ) && (READ_LATENCY == 0)) begin
          rd_load = 1'b1;
          rd_addr = mem.mem_addr;
        end
      end
      S_READ_WAIT: begin
        if (mem.mem_enable && (wait_cnt == '0)) begin
          rd_load = 1'b1;
          rd_addr = base_addr;
        end
      end
      S_READ_BURST: begin
        if (mem.mem_enable && !final_word) rd_load = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.mem_read_valid = (state == S_READ_BURST);
  assign mem.mem_write_req  = (state == S_WRITE_BURST);
  assign mem.mem_last       = ((state == S_READ_BURST) && final_word) ||
                              ((state == S_WRITE_BURST) && mem.mem_enable &&
                               (final_word || mem.mem_finishes_op));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_addr <= '0;
      count     <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem.mem_enable) begin
            base_addr <= mem.mem_addr;
            count     <= mem.mem_op_size ? CW'(1) : FULL_COUNT;
            idx       <= '0;
            wait_cnt  <= WAIT_INIT;
            if (mem.mem_rw == `MEM_WRITE)  state <= S_WRITE_BURST;
            else if (READ_LATENCY == 0)    state <= S_READ_BURST;
            else                           state <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (!mem.mem_enable)       state    <= S_IDLE;
          else if (wait_cnt == '0)   state    <= S_READ_BURST;
          else                       wait_cnt <= wait_cnt - WW'(1);
        end
        S_READ_BURST: begin
          if (!mem.mem_enable)  state <= S_IDLE;
          else if (final_word)  state <= S_DONE;
          else                  idx   <= idx + B'(1);
        end
        S_WRITE_BURST: begin
          if (!mem.mem_enable)                            state <= S_IDLE;
          else if (final_word || mem.mem_finishes_op)     state <= S_DONE;
          else                                            idx   <= idx + B'(1);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data is zero whenever no word is being presented.
  always_ff @(posedge clk) begin
    if (rst)          mem.mem_read <= '0;
    else if (rd_load) mem.mem_read <= mem_array[rd_addr];
    else              mem.mem_read <= '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_array[word_addr(base_addr, idx)] <= mem.mem_write;
  end

endmodule
